// File: rtl/vliw_mem_pkg.sv
// rtl/vliw_mem_pkg.sv - shared encodings for the VLIW MEM-stage load/store unit
//
// Purpose: access-size encodings, LSU FSM state type, data width, and the
//          alignment legality check shared by the LSU top and its aligner.
// Ports:   none (package).

package vliw_mem_pkg;

  localparam int DATA_W = 32;

  // Access size as presented on in_size.
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_X = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;

  // True when the op must be rejected without touching memory:
  // half needs a 2-byte aligned address, word a 4-byte aligned one,
  // and size 3 has no meaning.
  function automatic logic op_illegal(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = |off;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational byte-lane steering for the load/store unit
//
// Purpose: store side turns (size, byte offset, LSB-aligned data) into byte
//          enables and lane-replicated write data; load side picks the
//          addressed byte/half out of a memory word and sign/zero-extends it.
// Ports:
//   st_size, st_off, st_wdata -> st_be, st_lane_wdata     (store path)
//   ld_size, ld_off, ld_unsigned, ld_rdata -> ld_data      (load path)

module lsu_align
  import vliw_mem_pkg::*;
(
  input  logic [1:0]        st_size,
  input  logic [1:0]        st_off,
  input  logic [DATA_W-1:0] st_wdata,
  output logic [3:0]        st_be,
  output logic [DATA_W-1:0] st_lane_wdata,
  input  logic [1:0]        ld_size,
  input  logic [1:0]        ld_off,
  input  logic              ld_unsigned,
  input  logic [DATA_W-1:0] ld_rdata,
  output logic [DATA_W-1:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store: enables shift with the offset; data is replicated so the addressed
  // lane always carries the value regardless of offset.
  always_comb begin
    st_be         = 4'b0000;
    st_lane_wdata = st_wdata;
    case (st_size)
      SZ_B: begin
        st_be         = 4'b0001 << st_off;
        st_lane_wdata = {4{st_wdata[7:0]}};
      end
      SZ_H: begin
        st_be         = 4'b0011 << st_off;
        st_lane_wdata = {2{st_wdata[15:0]}};
      end
      SZ_W: begin
        st_be         = 4'b1111;
        st_lane_wdata = st_wdata;
      end
      default: begin
        st_be         = 4'b0000;
        st_lane_wdata = st_wdata;
      end
    endcase
  end

  always_comb begin
    ld_byte = 8'h00;
    case (ld_off)
      2'd0:    ld_byte = ld_rdata[7:0];
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      default: ld_byte = ld_rdata[31:24];
    endcase
    ld_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
  end

  always_comb begin
    ld_data = ld_rdata;
    case (ld_size)
      SZ_B:    ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
      SZ_H:    ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/vliw_lsu.sv
// rtl/vliw_lsu.sv - VLIW MEM-stage load/store unit, one outstanding access
//
// Purpose: accepts one load/store per handshake, issues a word-indexed memory
//          request with byte enables, and returns extended load data or a
//          store-done pulse. Misaligned/illegal ops and memory timeouts pulse err.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   in_valid/in_ready + in_* fields     op from EX
//   mem_req/we/addr/be/wdata, mem_gnt   request channel to data memory
//   mem_rvalid/mem_rdata                read return
//   wb_valid/wb_rd/wb_data              load writeback (1-cycle pulse)
//   st_done, err                        store commit / error pulses

module vliw_lsu
  import vliw_mem_pkg::*;
#(
  parameter int ADDR_W  = 22,
  parameter int RD_W    = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_store,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [ADDR_W+1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [RD_W-1:0]   in_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              st_done,
  output logic              err
);

  // Counter holds 0..TIMEOUT-1; the abort fires in the TIMEOUT-th waiting cycle.
  localparam int              CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Captured op.
  logic              is_store_q, is_store_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        off_q, off_d;
  logic [RD_W-1:0]   rd_q, rd_d;

  // Registered outputs.
  logic              in_ready_q, in_ready_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              wb_valid_q, wb_valid_d;
  logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              st_done_q, st_done_d;
  logic              err_q, err_d;

  logic [3:0]        st_be;
  logic [DATA_W-1:0] st_lane_wdata;
  logic [DATA_W-1:0] ld_ext;

  // Store steering works on the incoming op (registered into mem_* at accept);
  // load extraction works on the captured op against live mem_rdata.
  lsu_align u_align (
    .st_size       (in_size),
    .st_off        (in_addr[1:0]),
    .st_wdata      (in_wdata),
    .st_be         (st_be),
    .st_lane_wdata (st_lane_wdata),
    .ld_size       (size_q),
    .ld_off        (off_q),
    .ld_unsigned   (uns_q),
    .ld_rdata      (mem_rdata),
    .ld_data       (ld_ext)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    is_store_d  = is_store_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    rd_d        = rd_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    wb_valid_d  = 1'b0;
    st_done_d   = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Stray gnt/rvalid (including a late rvalid after timeout) are ignored here.
        if (in_valid) begin
          if (op_illegal(in_size, in_addr[1:0])) begin
            err_d = 1'b1;
          end else begin
            is_store_d  = in_is_store;
            size_d      = in_size;
            uns_d       = in_unsigned;
            off_d       = in_addr[1:0];
            rd_d        = in_rd;
            mem_req_d   = 1'b1;
            mem_we_d    = in_is_store;
            mem_addr_d  = in_addr[ADDR_W+1:2];
            mem_be_d    = st_be;
            mem_wdata_d = st_lane_wdata;
            state_d     = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          if (is_store_q) begin
            st_done_d = 1'b1;
            state_d   = ST_RESP;
          end else if (mem_rvalid) begin
            // Zero-wait memory: data returns with the grant.
            wb_valid_d = 1'b1;
            wb_data_d  = ld_ext;
            wb_rd_d    = rd_q;
            state_d    = ST_RESP;
          end else begin
            state_d = ST_WAIT_R;
          end
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_WAIT_R: begin
        if (mem_rvalid) begin
          wb_valid_d = 1'b1;
          wb_data_d  = ld_ext;
          wb_rd_d    = rd_q;
          state_d    = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      is_store_q  <= 1'b0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      off_q       <= 2'd0;
      rd_q        <= '0;
      in_ready_q  <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      st_done_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_store_q  <= is_store_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
      in_ready_q  <= in_ready_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      st_done_q   <= st_done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign st_done   = st_done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_vliw_lsu.sv
// tb/tb_vliw_lsu.sv - directed self-checking bench for vliw_lsu

module tb_vliw_lsu;

  localparam int AW = 22;
  localparam int RW = 5;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_is_store = 1'b0;
  logic [1:0]    in_size = 2'd0;
  logic          in_unsigned = 1'b0;
  logic [AW+1:0] in_addr = '0;
  logic [31:0]   in_wdata = '0;
  logic [RW-1:0] in_rd = '0;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [31:0]   mem_rdata = '0;
  logic          wb_valid;
  logic [RW-1:0] wb_rd;
  logic [31:0]   wb_data;
  logic          st_done;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  vliw_lsu #(.ADDR_W(AW), .RD_W(RW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_is_store (in_is_store),
    .in_size     (in_size),
    .in_unsigned (in_unsigned),
    .in_addr     (in_addr),
    .in_wdata    (in_wdata),
    .in_rd       (in_rd),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .st_done     (st_done),
    .err         (err)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic st, input logic [1:0] sz, input logic uns,
                       input logic [AW+1:0] a, input logic [31:0] wd, input logic [RW-1:0] rd);
    in_valid    = 1'b1;
    in_is_store = st;
    in_size     = sz;
    in_unsigned = uns;
    in_addr     = a;
    in_wdata    = wd;
    in_rd       = rd;
  endtask

  // Zero-wait load: gnt and rvalid high together while in REQ.
  task automatic load_zw(input string tag, input logic [1:0] sz, input logic uns,
                         input logic [AW+1:0] a, input logic [31:0] rdata, input logic [RW-1:0] rd,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be, input logic [31:0] exp);
    issue(1'b0, sz, uns, a, 32'h0, rd);
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = rdata;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, " req"}, 32'(mem_req), 32'd1);
    chk({tag, " we"}, 32'(mem_we), 32'd0);
    chk({tag, " addr"}, 32'(mem_addr), exp_addr);
    chk({tag, " be"}, 32'(mem_be), 32'(exp_be));
    @(negedge clk);
    chk({tag, " wb_valid"}, 32'(wb_valid), 32'd1);
    chk({tag, " wb_data"}, wb_data, exp);
    chk({tag, " wb_rd"}, 32'(wb_rd), 32'(rd));
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    chk({tag, " wb_valid drop"}, 32'(wb_valid), 32'd0);
    chk({tag, " ready back"}, 32'(in_ready), 32'd1);
  endtask

  // Zero-wait store.
  task automatic store_zw(input string tag, input logic [1:0] sz, input logic [AW+1:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd);
    issue(1'b1, sz, 1'b0, a, wd, '0);
    mem_gnt = 1'b1;
    chk({tag, " ready idle"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, " req"}, 32'(mem_req), 32'd1);
    chk({tag, " we"}, 32'(mem_we), 32'd1);
    chk({tag, " addr"}, 32'(mem_addr), exp_addr);
    chk({tag, " be"}, 32'(mem_be), 32'(exp_be));
    chk({tag, " wdata"}, mem_wdata, exp_wd);
    chk({tag, " ready busy"}, 32'(in_ready), 32'd0);
    chk({tag, " st_done early"}, 32'(st_done), 32'd0);
    @(negedge clk);
    mem_gnt = 1'b0;
    chk({tag, " st_done"}, 32'(st_done), 32'd1);
    chk({tag, " req drop"}, 32'(mem_req), 32'd0);
    chk({tag, " ready resp"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    chk({tag, " st_done drop"}, 32'(st_done), 32'd0);
    chk({tag, " ready back"}, 32'(in_ready), 32'd1);
  endtask

  // Misaligned/illegal op: no request, err pulse next cycle, stays ready.
  task automatic bad_op(input string tag, input logic [1:0] sz, input logic [AW+1:0] a);
    issue(1'b0, sz, 1'b0, a, 32'h0, 5'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, " no req"}, 32'(mem_req), 32'd0);
    chk({tag, " err"}, 32'(err), 32'd1);
    chk({tag, " ready"}, 32'(in_ready), 32'd1);
    chk({tag, " no wb"}, 32'(wb_valid), 32'd0);
    @(negedge clk);
    chk({tag, " err drop"}, 32'(err), 32'd0);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst wb_valid", 32'(wb_valid), 32'd0);
    chk("rst st_done", 32'(st_done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst mem_be", 32'(mem_be), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Word store 0x10 <- DEADBEEF
    store_zw("st_w", 2'd2, 24'h10, 32'hDEADBEEF, 32'd4, 4'b1111, 32'hDEADBEEF);
    // Half store 0xBEEF at 0x6 (upper input bits are don't-care)
    store_zw("st_h", 2'd1, 24'h6, 32'hFFFFBEEF, 32'd1, 4'b1100, 32'hBEEFBEEF);
    // Byte store 0xA5 at 0x1
    store_zw("st_b", 2'd0, 24'h1, 32'h123456A5, 32'd0, 4'b0010, 32'hA5A5A5A5);

    // Loads
    load_zw("ld_b_s", 2'd0, 1'b0, 24'h13, 32'h80123456, 5'd7, 32'd4, 4'b1000, 32'hFFFFFF80);
    load_zw("ld_b_u", 2'd0, 1'b1, 24'h13, 32'h80123456, 5'd9, 32'd4, 4'b1000, 32'h00000080);
    load_zw("ld_h_s", 2'd1, 1'b0, 24'h2, 32'h1234ABCD, 5'd3, 32'd0, 4'b1100, 32'h00001234);
    load_zw("ld_h_neg", 2'd1, 1'b0, 24'h0, 32'h1234ABCD, 5'd4, 32'd0, 4'b0011, 32'hFFFFABCD);
    load_zw("ld_h_u", 2'd1, 1'b1, 24'h0, 32'h1234ABCD, 5'd5, 32'd0, 4'b0011, 32'h0000ABCD);
    load_zw("ld_w", 2'd2, 1'b0, 24'h8, 32'h87654321, 5'd31, 32'd2, 4'b1111, 32'h87654321);

    // Misaligned / illegal
    bad_op("mis_w", 2'd2, 24'h5);
    bad_op("mis_h", 2'd1, 24'h3);
    bad_op("illegal", 2'd3, 24'h0);

    // Slow memory: gnt low 3 cycles, then rvalid 4 cycles after grant
    issue(1'b0, 2'd2, 1'b0, 24'h20, 32'h0, 5'd12);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("slow req held", 32'(mem_req), 32'd1);
      chk("slow addr held", 32'(mem_addr), 32'd8);
      chk("slow be held", 32'(mem_be), 32'hF);
      chk("slow we held", 32'(mem_we), 32'd0);
      chk("slow ready low", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    chk("slow req before gnt", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("slow wait req", 32'(mem_req), 32'd0);
      chk("slow wait no wb", 32'(wb_valid), 32'd0);
      chk("slow wait ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("slow wb_valid", 32'(wb_valid), 32'd1);
    chk("slow wb_data", wb_data, 32'hCAFEF00D);
    chk("slow wb_rd", 32'(wb_rd), 32'd12);
    chk("slow ready resp", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("slow wb once", 32'(wb_valid), 32'd0);
    chk("slow ready back", 32'(in_ready), 32'd1);

    // Timeout in REQ: gnt never comes
    issue(1'b0, 2'd2, 1'b0, 24'h40, 32'h0, 5'd2);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < TO; i++) begin
      chk("to req held", 32'(mem_req), 32'd1);
      chk("to no err yet", 32'(err), 32'd0);
      @(negedge clk);
    end
    chk("to err", 32'(err), 32'd1);
    chk("to req drop", 32'(mem_req), 32'd0);
    chk("to no wb", 32'(wb_valid), 32'd0);
    chk("to ready", 32'(in_ready), 32'd1);
    // Late rvalid and stray gnt in IDLE are ignored
    mem_rvalid = 1'b1; mem_gnt = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    chk("to err drop", 32'(err), 32'd0);
    @(negedge clk);
    chk("stray no wb", 32'(wb_valid), 32'd0);
    chk("stray no st_done", 32'(st_done), 32'd0);
    chk("stray no req", 32'(mem_req), 32'd0);
    chk("stray ready", 32'(in_ready), 32'd1);

    // Reset in WAIT_R
    issue(1'b0, 2'd2, 1'b0, 24'h10, 32'h0, 5'd6);
    @(negedge clk);
    in_valid = 1'b0;
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("wr ready low", 32'(in_ready), 32'd0);
    chk("wr addr", 32'(mem_addr), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("async ready", 32'(in_ready), 32'd1);
    chk("async addr", 32'(mem_addr), 32'd0);
    chk("async wb", 32'(wb_valid), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("post rst no wb", 32'(wb_valid), 32'd0);
    chk("post rst ready", 32'(in_ready), 32'd1);
    chk("post rst no req", 32'(mem_req), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vliw_lsu.md
Name: vliw_lsu

Overview:
- Load/store unit of the VLIW MEM stage; sits directly upstream of the data memory array.
- Accepts one load/store op per handshake from the EX stage and translates byte addresses into word-indexed memory accesses with byte enables.
- Returns sign/zero-extended load data to writeback. One outstanding memory transaction at a time.

Parameters:
- ADDR_W, 22, word-index width of data memory (memory depth 2**ADDR_W words of 32 bits)
- RD_W, 5, destination register index width
- TIMEOUT, 255, max cycles waiting on mem_gnt/mem_rvalid before error abort

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  EX op valid
- in_ready  out  1  LSU can accept op
- in_is_store  in  1  1=store, 0=load
- in_size  in  2  0=byte, 1=half, 2=word, 3=illegal
- in_unsigned  in  1  zero-extend loads when 1
- in_addr  in  ADDR_W+2  byte address
- in_wdata  in  32  store data (LSB-aligned)
- in_rd  in  RD_W  load destination register
- mem_req  out  1  memory request
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  word index (in_addr[ADDR_W+1:2])
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-shifted store data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data
- wb_valid  out  1  load result valid (1-cycle pulse)
- wb_rd  out  RD_W  destination register
- wb_data  out  32  extended load data
- st_done  out  1  store committed (1-cycle pulse)
- err  out  1  misaligned/illegal/timeout (1-cycle pulse)

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0 except in_ready=1; timeout counter 0; captured op registers 0.
- FSM states: IDLE, REQ, WAIT_R, RESP.
- IDLE: in_ready=1. On in_valid, capture op.
  - Misalignment rule: half needs addr[0]=0; word needs addr[1:0]=0; size 3 is illegal.
  - Misaligned/illegal: no memory access; err=1 next cycle; stay IDLE.
  - Otherwise go to REQ.
- REQ: mem_req=1 with stable mem_we/addr/be/wdata until mem_gnt.
  - On gnt, a store goes to RESP (st_done next cycle); a load goes to WAIT_R.
- WAIT_R: on mem_rvalid, register extended data, go to RESP.
  - mem_rvalid in the same cycle as gnt is legal: a load then goes straight from REQ to RESP.
- RESP: one cycle; pulse wb_valid (load) or st_done (store); return to IDLE. in_ready=0 during REQ/WAIT_R/RESP.
- Load latency is exactly 2 cycles from accept to wb_valid with zero-wait memory (gnt and rvalid the same cycle).
- Byte enables: byte -> 4'b0001<<addr[1:0]; half -> 4'b0011<<addr[1:0]; word -> 4'b1111.
- mem_wdata: byte replicated to all 4 lanes; half replicated to both halves; word as-is.
- Load extraction: byte = mem_rdata[8*addr[1:0]+:8]; half = mem_rdata[16*addr[1]+:16]; sign-extend unless in_unsigned.
- Timeout counter runs in REQ/WAIT_R and clears on state change.
  - Counter reaching TIMEOUT: drop mem_req, pulse err, no wb_valid/st_done, return to IDLE.
  - A late mem_rvalid arriving in IDLE is ignored.
- Stray mem_gnt/mem_rvalid in IDLE are ignored.
- wb_valid, st_done and err are mutually exclusive; at most one pulses per op.
- Reset mid-transaction aborts immediately; no completion pulse is issued.

Decomposition:
- Shared package vliw_mem_pkg: size encodings (SZ_B, SZ_H, SZ_W), LSU state enum, DATA_W=32.
- One natural sub-module: lsu_align. Purely combinational: byte enables, store lane replication, load extract/extend.

Test Plan:
- Word store addr 0x10, wdata 0xDEADBEEF, zero-wait memory -> mem_addr=4, mem_be=1111, st_done 2 cycles after accept.
- Byte load addr 0x13, signed, mem_rdata 0x80xxxxxx -> wb_data=0xFFFFFF80; unsigned -> 0x00000080; wb_rd matches.
- Half load addr 0x2 of word 0x1234ABCD signed -> wb_data=0x00001234; half store 0xBEEF at addr 0x6 -> mem_be=1100, mem_wdata=0xBEEFBEEF.
- Misaligned word load addr 0x5 -> no mem_req, err pulse next cycle, in_ready stays 1.
- mem_gnt held low 3 cycles, then rvalid 4 cycles later -> request signals stable throughout, wb_valid exactly once, in_ready low until RESP done.
- mem_gnt never asserted with TIMEOUT=8 -> err after 8 cycles in REQ, return to IDLE; rst_n pulled low in WAIT_R -> outputs to reset values asynchronously, no wb_valid.
